// File: rtl/display_scan_ctrl.sv
// rtl/display_scan_ctrl.sv - 4-digit 7-segment scan scheduler with frame snapshot and edit blink
module display_scan_ctrl #(
  parameter int DWELL_CYCLES = 1000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic [11:0] time_data,
  input  logic [11:0] set_data,
  input  logic        set_mode,
  input  logic [1:0]  set_field,
  output logic [11:0] data_show,
  output logic [2:0]  byte_status,
  output logic [3:0]  segment_byte_control,
  output logic        frame_tick
);

  localparam int DW = $clog2(DWELL_CYCLES);
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

  logic [DW-1:0] dwell_count;
  logic [FW-1:0] frame_count;
  logic          blink_phase;
  logic [1:0]    prev_field;
  logic          prev_mode;

  logic step_end;
  logic frame_wrap;
  logic edit_change;
  logic visible;

  assign step_end    = enable && (dwell_count == DWELL_LAST);
  assign frame_wrap  = step_end && (byte_status == 3'd7);
  assign edit_change = (set_field != prev_field) || (set_mode != prev_mode);
  // A fresh edit selection is shown immediately, even if the stored phase is dark.
  assign visible     = blink_phase || edit_change;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dwell_count          <= '0;
      byte_status          <= 3'd0;
      frame_count          <= '0;
      blink_phase          <= 1'b1;
      prev_field           <= 2'd0;
      prev_mode            <= 1'b0;
      data_show            <= 12'd0;
      frame_tick           <= 1'b0;
      segment_byte_control <= 4'b0000;
    end else begin
      prev_field <= set_field;
      prev_mode  <= set_mode;
      frame_tick <= frame_wrap;

      if (enable) begin
        dwell_count <= step_end ? '0 : dwell_count + 1'b1;
        if (step_end)
          byte_status <= byte_status + 3'd1;
      end

      if (frame_wrap)
        data_show <= set_mode ? set_data : time_data;

      if (edit_change) begin
        frame_count <= '0;
        blink_phase <= 1'b1;
      end else if (frame_wrap) begin
        if (frame_count == FRAME_LAST) begin
          frame_count <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          frame_count <= frame_count + 1'b1;
        end
      end

      if (!enable)
        segment_byte_control <= 4'b0000;
      else if (set_mode && !visible && set_field == 2'd1)
        segment_byte_control <= 4'b1100;
      else if (set_mode && !visible && set_field == 2'd2)
        segment_byte_control <= 4'b0011;
      else
        segment_byte_control <= 4'b1111;
    end
  end

endmodule
